// File: rtl/rll_key_pkg.sv
// Shared types for the RLL key loader: key width, key vector and loader FSM states.
package rll_key_pkg;

  localparam int KEY_WIDTH = 16;

  typedef logic [KEY_WIDTH-1:0] key_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } key_ld_state_t;

endpackage

// File: rtl/rll_key_shadow.sv
// Shadow key register: captures serial bits at the counter position and keeps a running
// even-parity accumulator over data and parity bits.
module rll_key_shadow
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = rll_key_pkg::KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 shift_i,
  input  logic                 bit_i,
  output logic [KEY_WIDTH-1:0] shadow_o,
  output logic                 done_o,
  output logic                 parity_ok_o
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);

  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_q, par_d;

  assign done_o      = (cnt_q == CNT_W'(KEY_WIDTH));
  // The accumulator folds in the parity bit as well, so a good frame leaves it at 0.
  assign parity_ok_o = ~par_q;
  assign shadow_o    = shadow_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave a latch behind.
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    if (clear_i) begin
      shadow_d = '0;
      cnt_d    = '0;
      par_d    = 1'b0;
    end else if (shift_i) begin
      par_d = par_q ^ bit_i;
      if (!done_o) begin
        for (int i = 0; i < KEY_WIDTH; i++) begin
          if (cnt_q == CNT_W'(i)) shadow_d[i] = bit_i;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
    end
  end

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader for the RLL-locked core: shifts in KEY_WIDTH bits plus even parity
// and updates the parallel key bus only on a verified commit.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = rll_key_pkg::KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 key_bit,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_armed,
  output logic                 load_busy,
  output logic                 load_error
);

  key_ld_state_t        state_q;
  logic [KEY_WIDTH-1:0] key_out_q;
  logic [KEY_WIDTH-1:0] shadow;
  logic                 key_armed_q, load_busy_q, load_error_q, key_ready_q;
  logic                 xfer, clear, done, parity_ok;

  // A restart in SHIFT wins over a transfer offered in the same cycle.
  assign xfer  = key_valid && key_ready_q && !load_start;
  assign clear = load_start && (state_q != CHECK);

  rll_key_shadow #(.KEY_WIDTH(KEY_WIDTH)) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .shift_i     (xfer),
    .bit_i       (key_bit),
    .shadow_o    (shadow),
    .done_o      (done),
    .parity_ok_o (parity_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      key_out_q    <= '0;
      key_armed_q  <= 1'b0;
      load_busy_q  <= 1'b0;
      load_error_q <= 1'b0;
      key_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q      <= SHIFT;
            load_error_q <= 1'b0;
            load_busy_q  <= 1'b1;
            key_ready_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (xfer && done) begin
            state_q     <= CHECK;
            key_ready_q <= 1'b0;
          end
        end
        CHECK: begin
          if (parity_ok) begin
            key_out_q   <= shadow;
            key_armed_q <= 1'b1;
          end else begin
            load_error_q <= 1'b1;
          end
          state_q     <= IDLE;
          load_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          load_busy_q <= 1'b0;
          key_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_out    = key_out_q;
  assign key_armed  = key_armed_q;
  assign load_busy  = load_busy_q;
  assign load_error = load_error_q;
  assign key_ready  = key_ready_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: directed scenarios plus random frames checked
// against a frame-level model of the committed key and status flags.
module tb_rll_key_loader;
  import rll_key_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     load_start = 1'b0;
  logic     key_bit = 1'b0;
  logic     key_valid = 1'b0;
  logic     key_ready, key_armed, load_busy, load_error;
  key_vec_t key_out;

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;

  // Frame-level reference: what the key bus and flags should show after each load.
  key_vec_t m_out;
  logic     m_armed, m_err;

  always #5 clk = ~clk;

  rll_key_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .key_armed  (key_armed),
    .load_busy  (load_busy),
    .load_error (load_error)
  );

  always @(posedge clk) begin
    if (!rst && key_valid && key_ready && !load_start) xfer_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_out   = '0;
    m_armed = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_err = 1'b0;
  endtask

  // Offer one bit after 'gap' idle cycles and wait (bounded) for it to be taken.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      key_valid = 1'b0;
      key_bit   = 1'($urandom);
      tick();
    end
    key_valid = 1'b1;
    key_bit   = b;
    for (int t = 0; t < 64 && key_ready !== 1'b1; t++) tick();
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_bit_timeout key_ready=%b required=1", key_ready);
    end
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_data(input key_vec_t key, input int nbits, input int maxgap);
    for (int i = 0; i < nbits; i++) send_bit(key[i], $urandom_range(0, maxgap));
  endtask

  // Parity transfer, then check the CHECK cycle and the committed result.
  task automatic finish_frame(input key_vec_t key, input logic par, input logic start_in_check);
    send_bit(par, 0);
    n_cmp++;
    if (key_out !== m_out || load_busy !== 1'b1 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL check_cycle out=%h busy=%b ready=%b required out=%h busy=1 ready=0",
               key_out, load_busy, key_ready, m_out);
    end
    load_start = start_in_check;
    tick();
    load_start = 1'b0;
    if ((($countones(key) + int'(par)) % 2) == 0) begin
      m_out   = key;
      m_armed = 1'b1;
    end else begin
      m_err = 1'b1;
    end
    n_cmp++;
    if (key_out !== m_out || key_armed !== m_armed || load_error !== m_err) begin
      n_bad++;
      $display("FAIL commit out=%h armed=%b err=%b required out=%h armed=%b err=%b",
               key_out, key_armed, load_error, m_out, m_armed, m_err);
    end
    n_cmp++;
    if (load_busy !== 1'b0 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL after_commit busy=%b ready=%b required 0 0", load_busy, key_ready);
    end
  endtask

  task automatic load_frame(input key_vec_t key, input logic par, input int maxgap);
    start_load();
    send_data(key, KEY_WIDTH, maxgap);
    finish_frame(key, par, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (key_out !== '0 || key_armed !== 1'b0 || load_busy !== 1'b0 ||
        load_error !== 1'b0 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset out=%h armed=%b busy=%b err=%b ready=%b required all 0",
               key_out, key_armed, load_busy, load_error, key_ready);
    end
  endtask

  task automatic test_basic();
    load_frame(16'hA5C3, 1'b0, 0);
  endtask

  task automatic test_bad_parity();
    do_reset();
    load_frame(16'h0001, 1'b0, 0);
    load_frame(16'h0001, 1'b1, 0);
  endtask

  task automatic test_restart();
    load_frame(16'hFFFF, 1'b0, 0);
    start_load();
    send_data(16'h1234, 7, 1);
    load_start = 1'b1;
    key_valid  = 1'b1;
    key_bit    = 1'b1;
    tick();
    load_start = 1'b0;
    key_valid  = 1'b0;
    n_cmp++;
    if (key_out !== 16'hFFFF || load_busy !== 1'b1 || key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL restart out=%h busy=%b ready=%b required out=ffff busy=1 ready=1",
               key_out, load_busy, key_ready);
    end
    send_data(16'h1234, KEY_WIDTH, 1);
    finish_frame(16'h1234, 1'b1, 1'b0);
  endtask

  task automatic test_gaps();
    xfer_cnt = 0;
    load_frame(16'h8001, 1'b0, 5);
    n_cmp++;
    if (xfer_cnt !== 17) begin
      n_bad++;
      $display("FAIL gap_transfers got=%0d required=17", xfer_cnt);
    end
  endtask

  task automatic test_rst_mid();
    load_frame(16'h00FF, 1'b0, 0);
    start_load();
    send_data(16'hC3C3, 10, 0);
    rst = 1'b1;
    tick();
    model_reset();
    n_cmp++;
    if (key_out !== '0 || key_armed !== 1'b0 || load_busy !== 1'b0 ||
        load_error !== 1'b0 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid out=%h armed=%b busy=%b err=%b ready=%b required all 0",
               key_out, key_armed, load_busy, load_error, key_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_valid();
    int stray;
    load_frame(16'h5A5A, 1'b0, 0);
    xfer_cnt = 0;
    stray    = 0;
    for (int c = 0; c < 20; c++) begin
      key_valid = 1'b1;
      key_bit   = 1'($urandom);
      tick();
      if (key_ready !== 1'b0 || load_busy !== 1'b0) stray++;
    end
    key_valid = 1'b0;
    n_cmp++;
    if (stray !== 0 || xfer_cnt !== 0) begin
      n_bad++;
      $display("FAIL idle_valid stray_cycles=%0d transfers=%0d required 0 0", stray, xfer_cnt);
    end
    n_cmp++;
    if (key_out !== m_out || key_armed !== m_armed || load_error !== m_err) begin
      n_bad++;
      $display("FAIL idle_hold out=%h armed=%b err=%b required out=%h armed=%b err=%b",
               key_out, key_armed, load_error, m_out, m_armed, m_err);
    end
  endtask

  task automatic test_start_in_check();
    key_vec_t k;
    k = key_vec_t'($urandom);
    start_load();
    send_data(k, KEY_WIDTH, 0);
    finish_frame(k, ^k, 1'b1);
  endtask

  task automatic test_random();
    key_vec_t k;
    logic     p;
    for (int n = 0; n < 10; n++) begin
      k = key_vec_t'($urandom);
      p = (^k) ^ ($urandom_range(0, 3) == 0);
      load_frame(k, p, 2);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_bad_parity();
    test_restart();
    test_gaps();
    test_rst_mid();
    test_idle_valid();
    test_start_in_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
